mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_if.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the pipeline MEM stage controller and its environment:
// pipeline request/response signals plus the 16-bit external SRAM pins.
interface mem_stage_ctrl_if;
  // Pipeline handshake: a request (wr_en or rd_en) is taken when the controller
  // is idle; ready stays low while the access is in flight, freezing upstream
  // stages, and returns high for exactly one DONE cycle before the next request.
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic [15:0] sram_dq_in;

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: splits a 32-bit load/store into two 16-bit SRAM
// half-accesses of ACCESS_CYCLES cycles each, stalling the pipeline meanwhile.
module mem_stage_ctrl #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_ctrl_if.slave   bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2:0] LAST = 3'(ACCESS_CYCLES - 1);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        req;
  logic        last;
  logic [31:0] off;
  logic        off_unused;

  logic        ready_c;
  logic [17:0] sram_addr_c;
  logic [15:0] sram_dq_out_c;
  logic        sram_dq_oe_c;
  logic        sram_we_n_c;

  assign req  = bus.wr_en | bus.rd_en;
  assign last = (cnt == LAST);
  // Offset wraps modulo 2^32; only bits 18:2 select the halfword pair.
  assign off        = addr_q - BASE_ADDR;
  assign off_unused = ^{off[31:19], off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request is latched on IDLE->LO; a simultaneous wr_en/rd_en counts as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (state == IDLE && req) begin
      op_wr   <= bus.wr_en;
      addr_q  <= bus.address;
      wdata_q <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'd0;
    end else if (!op_wr && last) begin
      if (state == LO)      rdata_q[15:0]  <= bus.sram_dq_in;
      else if (state == HI) rdata_q[31:16] <= bus.sram_dq_in;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ready_c       = 1'b1;
    sram_addr_c   = 18'd0;
    sram_dq_out_c = 16'd0;
    sram_dq_oe_c  = 1'b0;
    sram_we_n_c   = 1'b1;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = LO;
          cnt_nx   = 3'd0;
          ready_c  = 1'b0;
        end
      end
      LO: begin
        ready_c       = 1'b0;
        sram_addr_c   = {off[18:2], 1'b0};
        sram_dq_out_c = op_wr ? wdata_q[15:0] : 16'd0;
        sram_dq_oe_c  = op_wr;
        sram_we_n_c   = ~op_wr;
        if (last) begin
          state_nx = HI;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      HI: begin
        ready_c       = 1'b0;
        sram_addr_c   = {off[18:2], 1'b1};
        sram_dq_out_c = op_wr ? wdata_q[31:16] : 16'd0;
        sram_dq_oe_c  = op_wr;
        sram_we_n_c   = ~op_wr;
        if (last) begin
          state_nx = DONE;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase
    // A pending request must not stall the pipeline while reset is held.
    if (!rst) ready_c = 1'b1;
  end

  assign bus.ready       = ready_c;
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = sram_addr_c;
  assign bus.sram_dq_out = sram_dq_out_c;
  assign bus.sram_dq_oe  = sram_dq_oe_c;
  assign bus.sram_we_n   = sram_we_n_c;
  assign state_dbg       = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: three instances (ACCESS_CYCLES 1, 2, 7) sharing one
// SRAM model; table-driven accesses plus reset-abort and back-to-back sequences.
module tb_mem_stage_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  int          req_sel;

  mem_stage_ctrl_if if1();
  mem_stage_ctrl_if if2();
  mem_stage_ctrl_if if7();
  logic [1:0] st1, st2, st7;

  assign if1.wr_en = (req_sel == 1) ? wr_en : 1'b0;
  assign if1.rd_en = (req_sel == 1) ? rd_en : 1'b0;
  assign if2.wr_en = (req_sel == 2) ? wr_en : 1'b0;
  assign if2.rd_en = (req_sel == 2) ? rd_en : 1'b0;
  assign if7.wr_en = (req_sel == 7) ? wr_en : 1'b0;
  assign if7.rd_en = (req_sel == 7) ? rd_en : 1'b0;
  assign if1.address = address;
  assign if2.address = address;
  assign if7.address = address;
  assign if1.write_data = write_data;
  assign if2.write_data = write_data;
  assign if7.write_data = write_data;

  mem_stage_ctrl #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (.clk(clk), .rst(rst), .bus(if1), .state_dbg(st1));
  mem_stage_ctrl #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) dut2 (.clk(clk), .rst(rst), .bus(if2), .state_dbg(st2));
  mem_stage_ctrl #(.ACCESS_CYCLES(7), .BASE_ADDR(32'd1024)) dut7 (.clk(clk), .rst(rst), .bus(if7), .state_dbg(st7));

  // ---------------- SRAM model ----------------
  logic [15:0] sram_mem [0:262143];
  assign if1.sram_dq_in = sram_mem[if1.sram_addr];
  assign if2.sram_dq_in = sram_mem[if2.sram_addr];
  assign if7.sram_dq_in = sram_mem[if7.sram_addr];
  always @(posedge clk) begin
    if (!if1.sram_we_n) sram_mem[if1.sram_addr] <= if1.sram_dq_out;
    if (!if2.sram_we_n) sram_mem[if2.sram_addr] <= if2.sram_dq_out;
    if (!if7.sram_we_n) sram_mem[if7.sram_addr] <= if7.sram_dq_out;
  end

  // ---------------- observation mux ----------------
  logic        obs_ready, obs_oe, obs_we_n;
  logic [17:0] obs_addr;
  logic [15:0] obs_dq;
  logic [31:0] obs_rd;
  always_comb begin
    obs_ready = if2.ready; obs_addr = if2.sram_addr; obs_dq = if2.sram_dq_out;
    obs_oe = if2.sram_dq_oe; obs_we_n = if2.sram_we_n; obs_rd = if2.read_data;
    case (req_sel)
      1: begin
        obs_ready = if1.ready; obs_addr = if1.sram_addr; obs_dq = if1.sram_dq_out;
        obs_oe = if1.sram_dq_oe; obs_we_n = if1.sram_we_n; obs_rd = if1.read_data;
      end
      7: begin
        obs_ready = if7.ready; obs_addr = if7.sram_addr; obs_dq = if7.sram_dq_out;
        obs_oe = if7.sram_dq_oe; obs_we_n = if7.sram_we_n; obs_rd = if7.read_data;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pins(input logic rdy, input logic [17:0] a,
                                       input logic [15:0] dq, input logic oe, input logic we_n);
    return {27'd0, rdy, a, dq, oe, we_n};
  endfunction

  function automatic logic [63:0] obs_pins();
    return pins(obs_ready, obs_addr, obs_dq, obs_oe, obs_we_n);
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] a_lo;
    logic [17:0] a_hi;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  // Issue one access and check every cycle from the request cycle to DONE.
  task automatic run_access(input string tag, input int sel, input int n, input vec_t v);
    logic [63:0] e;
    @(posedge clk); #1;
    req_sel = sel; wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
    for (int p = 0; p <= 2 * n + 1; p++) begin
      @(negedge clk);
      if (p == 0 || p == 2 * n + 1)
        e = pins(p == 2 * n + 1, 18'd0, 16'd0, 1'b0, 1'b1);
      else if (p <= n)
        e = pins(1'b0, v.a_lo, v.wr ? v.wdata[15:0] : 16'd0, v.wr, ~v.wr);
      else
        e = pins(1'b0, v.a_hi, v.wr ? v.wdata[31:16] : 16'd0, v.wr, ~v.wr);
      exp_q.push_back(e);
      check($sformatf("%s pins p%0d", tag, p), obs_pins());
      if (p == 2 * n + 1) begin
        exp_q.push_back({32'd0, v.exp_rd});
        check($sformatf("%s read_data", tag), {32'd0, obs_rd});
      end
      @(posedge clk); #1;
      if (p == 0) begin
        wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
      end
    end
  endtask

  // Two reads with rd_en held high: exactly one DONE and one IDLE cycle between them.
  task automatic back_to_back(input string tag, input int sel, input int n,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk); #1;
    req_sel = sel; wr_en = 1'b0; rd_en = 1'b1; address = a1;
    for (int p = 0; p <= 4 * n + 3; p++) begin
      @(negedge clk);
      exp_q.push_back({63'd0, (p == 2 * n + 1) || (p == 4 * n + 3)});
      check($sformatf("%s ready p%0d", tag, p), {63'd0, obs_ready});
      if (p == 2 * n + 1) begin
        exp_q.push_back({32'd0, e1});
        check($sformatf("%s read_data first", tag), {32'd0, obs_rd});
      end
      if (p == 4 * n + 3) begin
        exp_q.push_back({32'd0, e2});
        check($sformatf("%s read_data second", tag), {32'd0, obs_rd});
      end
      @(posedge clk); #1;
      if (p == 0) address = a2;
      if (p == 2 * n + 2) rd_en = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h00000, 18'h00001, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 18'h00001, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1031, 32'hCAFEF00D, 18'h00002, 18'h00003, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 18'h00002, 18'h00003, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 18'h3FFFF, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'h00000, 18'h00001, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'h00000000, 18'h3FFFE, 18'h3FFFF, 32'hA5A55A5A};
    vecs[7] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 18'h00001, 32'h12345678};

    // Reset with a request pending: outputs idle, ready high.
    rst = 1'b0; req_sel = 2; wr_en = 1'b1; rd_en = 1'b0;
    address = 32'd1024; write_data = 32'hFFFF0000;
    repeat (2) @(negedge clk);
    exp_q.push_back(pins(1'b1, 18'd0, 16'd0, 1'b0, 1'b1));
    check("reset pins", obs_pins());
    exp_q.push_back(64'd0);
    check("reset read_data", {32'd0, obs_rd});
    exp_q.push_back(64'd0);
    check("reset state", {62'd0, st2});
    wr_en = 1'b0;
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 8; i++) run_access($sformatf("vec%0d", i), 2, 2, vecs[i]);

    // read_data holds through idle cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_q.push_back({32'd0, 32'h12345678});
      check($sformatf("hold read_data c%0d", i), {32'd0, obs_rd});
    end

    // Reset in the second HI cycle of a read aborts it.
    @(posedge clk); #1;
    req_sel = 2; rd_en = 1'b1; address = 32'd1024;
    @(posedge clk); #1;
    rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(pins(1'b1, 18'd0, 16'd0, 1'b0, 1'b1));
    check("abort pins", obs_pins());
    exp_q.push_back(64'd0);
    check("abort read_data", {32'd0, obs_rd});
    exp_q.push_back(64'd0);
    check("abort state", {62'd0, st2});
    @(negedge clk); rst = 1'b1;
    v = '{1'b1, 1'b0, 32'd1024, 32'h0BADCAFE, 18'h00000, 18'h00001, 32'h00000000};
    run_access("post-abort write", 2, 2, v);
    v = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 18'h00000, 18'h00001, 32'h0BADCAFE};
    run_access("post-abort read", 2, 2, v);

    // ACCESS_CYCLES = 1
    v = '{1'b1, 1'b0, 32'd1024, 32'h11112222, 18'h00000, 18'h00001, 32'h00000000};
    run_access("n1 write a", 1, 1, v);
    v = '{1'b1, 1'b0, 32'd1028, 32'h33334444, 18'h00002, 18'h00003, 32'h00000000};
    run_access("n1 write b", 1, 1, v);
    back_to_back("n1 b2b", 1, 1, 32'd1024, 32'd1028, 32'h11112222, 32'h33334444);

    // ACCESS_CYCLES = 7
    v = '{1'b1, 1'b0, 32'd1032, 32'h55556666, 18'h00004, 18'h00005, 32'h00000000};
    run_access("n7 write a", 7, 7, v);
    v = '{1'b1, 1'b0, 32'd1036, 32'h77778888, 18'h00006, 18'h00007, 32'h00000000};
    run_access("n7 write b", 7, 7, v);
    back_to_back("n7 b2b", 7, 7, 32'd1032, 32'd1036, 32'h55556666, 32'h77778888);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
